// File: rtl/vga_color_gen.sv
// 640x480@60 VGA timing generator with a frame-latched solid colour source.
// All outputs are registered one cycle behind the (h,v) counter state.
module vga_color_gen (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] color_sel,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       blank_n,
  output logic       sync_n,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic [9:0] px_x,
  output logic [9:0] px_y,
  output logic       frame_start
);

  localparam logic [9:0] H_LAST     = 10'd799;
  localparam logic [9:0] H_VIS      = 10'd640;
  localparam logic [9:0] H_SYNC_LO  = 10'd656;
  localparam logic [9:0] H_SYNC_HI  = 10'd751;
  localparam logic [9:0] V_LAST     = 10'd524;
  localparam logic [9:0] V_VIS      = 10'd480;
  localparam logic [9:0] V_SYNC_LO  = 10'd490;
  localparam logic [9:0] V_SYNC_HI  = 10'd491;

  logic [9:0]  h_q, h_d, v_q, v_d;
  logic [2:0]  color_q, color_d;
  logic        hsync_q, hsync_d, vsync_q, vsync_d;
  logic        video_on_q, video_on_d, frame_start_q, frame_start_d;
  logic [23:0] rgb_q, rgb_d, lut_rgb;
  logic [9:0]  px_x_q, px_x_d, px_y_q, px_y_d;
  logic        h_end, v_end;

  always_comb begin
    h_end   = (h_q == H_LAST);
    v_end   = (v_q == V_LAST);
    h_d     = h_end ? 10'd0 : h_q + 10'd1;
    v_d     = v_q;
    if (h_end) v_d = v_end ? 10'd0 : v_q + 10'd1;
    // Colour only changes at the last pixel of a frame so no frame ever tears.
    color_d = (h_end && v_end) ? color_sel : color_q;

    hsync_d       = !((h_q >= H_SYNC_LO) && (h_q <= H_SYNC_HI));
    vsync_d       = !((v_q >= V_SYNC_LO) && (v_q <= V_SYNC_HI));
    video_on_d    = (h_q < H_VIS) && (v_q < V_VIS);
    frame_start_d = (h_q == 10'd0) && (v_q == 10'd0);
    px_x_d        = h_q;
    px_y_d        = v_q;

    lut_rgb = 24'h000000;
    case (color_q)
      3'd1:    lut_rgb = 24'hFF0000;
      3'd2:    lut_rgb = 24'h00FF00;
      3'd3:    lut_rgb = 24'h0000FF;
      3'd4:    lut_rgb = 24'hFFFFFF;
      default: lut_rgb = 24'h000000;
    endcase
    rgb_d = video_on_d ? lut_rgb : 24'h000000;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_q           <= 10'd0;
      v_q           <= 10'd0;
      color_q       <= 3'd0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
      rgb_q         <= 24'h000000;
      px_x_q        <= 10'd0;
      px_y_q        <= 10'd0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      color_q       <= color_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
      rgb_q         <= rgb_d;
      px_x_q        <= px_x_d;
      px_y_q        <= px_y_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign blank_n     = video_on_q;
  assign sync_n      = 1'b0;
  assign red         = rgb_q[23:16];
  assign green       = rgb_q[15:8];
  assign blue        = rgb_q[7:0];
  assign px_x        = px_x_q;
  assign px_y        = px_y_q;
  assign frame_start = frame_start_q;

endmodule
